onehot_decoder_hs: RTL and testbench
====================================

// Module: onehot_decoder_hs
// PURPOSE
//  Registered 3-to-8 index decoder: the receive-side counterpart of the
//  8-input priority encoder. It accepts an encoded index plus invalid flag
//  over a valid/ready handshake and drives a registered one-hot output.
//  Each output is held for a minimum of HOLD_CYCLES cycles, then released
//  on the downstream acknowledge. Invalid codes are dropped and counted.
// PARAMETERS
//  N_OUT        8   one-hot output width (2**IDX_W)
//  IDX_W        3   index width
//  HOLD_CYCLES  4   minimum cycles out_valid stays high per transaction (>=1)
//  ERR_CNT_W    8   width of the saturating error counter
// PORTS
//  clk         in   1          rising-edge clock
//  rst         in   1          asynchronous, active-high reset
//  in_valid    in   1          upstream index valid
//  in_ready    out  1          block can accept an index
//  in_idx      in   IDX_W      encoded index (encoder o)
//  in_invalid  in   1          upstream invalid flag (encoder invalid)
//  out_onehot  out  N_OUT      decoded one-hot, registered
//  out_valid   out  1          out_onehot is valid
//  out_ready   in   1          downstream acknowledge
//  busy        out  1          state != IDLE
//  err_clr     in   1          synchronous clear of err_count/err_flag
//  err_count   out  ERR_CNT_W  saturating count of rejected inputs
//  err_flag    out  1          sticky: at least one input rejected
// BEHAVIOUR
//  - Reset (async, any state): state=IDLE, out_onehot=0, out_valid=0,
//    hold counter=0, err_count=0, err_flag=0. Aborts any transaction.
//  - States: IDLE, HOLD, WAIT. in_ready = (state==IDLE), decoded from the
//    state register only. busy = !in_ready.
//  - Accept = in_valid & in_ready sampled at an edge.
//    - If in_invalid=0: at that edge out_onehot <= 1<<in_idx, out_valid<=1,
//      cnt <= HOLD_CYCLES-1, state <= HOLD.
//    - If in_invalid=1: reject. Stay IDLE, outputs unchanged (0), err_flag<=1,
//      err_count += 1, saturating at 2**ERR_CNT_W-1.
//    - Idx >= N_OUT is only possible if N_OUT < 2**IDX_W. Such an index is
//      treated as invalid.
//  - HOLD: on each edge, if cnt!=0 then cnt-=1, and out_ready is ignored.
//    If cnt==0 and out_ready=1, go to IDLE, out_valid<=0, out_onehot<=0.
//    If cnt==0 and out_ready=0, go to WAIT.
//  - WAIT: hold outputs. On an edge with out_ready=1, go to IDLE and clear
//    out_valid and out_onehot.
//  - With out_ready tied high, out_valid is high for exactly HOLD_CYCLES
//    cycles. The next accept is possible on the edge after release, so
//    throughput is 1 transaction per HOLD_CYCLES+1 cycles.
//  - out_onehot==0 whenever out_valid==0. It is exactly one-hot otherwise
//    and stable while out_valid=1.
//  - in_idx and in_invalid are sampled only at accept and ignored otherwise.
//  - err_clr with a simultaneous reject: the clear applies first, then the
//    reject counts, giving err_count=1 and err_flag=1.
//  - err_clr is independent of the data state machine.
// TESTING
//  1 Reset, then in_idx=5, in_invalid=0, pulse in_valid, out_ready=1
//    -> out_onehot=8'b0010_0000, out_valid high exactly 4 cycles,
//    in_ready low for those cycles.
//  2 Sweep in_idx 0..7 back to back with in_valid held high
//    -> onehot = 1<<idx for each, one accept every 5 cycles, no lost index.
//  3 in_invalid=1, in_idx=3
//    -> out_valid stays 0, err_count=1, err_flag=1, in_ready stays 1.
//  4 in_idx=2 with out_ready=0 for 10 cycles, then 1
//    -> state goes HOLD->WAIT, out_onehot=8'h04 held until the out_ready edge,
//    then out_valid=0.
//  5 Send 260 invalid inputs, then 1 with err_clr asserted on the same edge
//    -> err_count=255 before the clear, 1 after, err_flag=1.
//  6 Assert rst mid-HOLD, between edges
//    -> out_valid=0, out_onehot=0, in_ready=1 immediately, before the next edge.

Source files
------------

// File: rtl/onehot_decoder_hs.sv
// onehot_decoder_hs: registered index-to-one-hot decoder with valid/ready intake, minimum hold and error counting
module onehot_decoder_hs #(
  parameter int N_OUT       = 8,
  parameter int IDX_W       = 3,
  parameter int HOLD_CYCLES = 4,
  parameter int ERR_CNT_W   = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 in_valid_i,
  output logic                 in_ready_o,
  input  logic [IDX_W-1:0]     in_idx_i,
  input  logic                 in_invalid_i,
  output logic [N_OUT-1:0]     out_onehot_o,
  output logic                 out_valid_o,
  input  logic                 out_ready_i,
  output logic                 busy_o,
  input  logic                 err_clr_i,
  output logic [ERR_CNT_W-1:0] err_count_o,
  output logic                 err_flag_o
);
  localparam int NI    = 2 ** IDX_W;
  localparam int CNT_W = HOLD_CYCLES > 1 ? $clog2(HOLD_CYCLES) : 1;
  typedef enum logic [1:0] {IDLE, HOLD, WAIT} state_t;
  state_t               state_q, state_d;
  logic [N_OUT-1:0]     onehot_q, onehot_d;
  logic                 valid_q, valid_d;
  logic [CNT_W-1:0]     cnt_q, cnt_d;
  logic [ERR_CNT_W-1:0] err_cnt_q, err_cnt_d, err_base;
  logic                 err_flag_q, err_flag_d;
  logic [NI-1:0]        dec;
  logic                 accept, reject;
  assign in_ready_o   = state_q == IDLE;
  assign busy_o       = !in_ready_o;
  assign out_onehot_o = onehot_q;
  assign out_valid_o  = valid_q;
  assign err_count_o  = err_cnt_q;
  assign err_flag_o   = err_flag_q;
  // an index that decodes outside the N_OUT outputs lights no bit and is rejected
  assign dec    = NI'(1) << in_idx_i;
  assign accept = in_valid_i & in_ready_o;
  assign reject = accept & (in_invalid_i | ~|dec[N_OUT-1:0]);
  always_comb begin
    state_d  = state_q;
    onehot_d = onehot_q;
    valid_d  = valid_q;
    cnt_d    = cnt_q;
    unique case (state_q)
      IDLE: if (accept && !reject) begin
        state_d  = HOLD;
        onehot_d = dec[N_OUT-1:0];
        valid_d  = 1'b1;
        cnt_d    = CNT_W'(HOLD_CYCLES - 1);
      end
      HOLD: if (cnt_q != '0) cnt_d = cnt_q - 1'b1;
            else if (out_ready_i) begin
              state_d  = IDLE;
              onehot_d = '0;
              valid_d  = 1'b0;
            end else state_d = WAIT;
      WAIT: if (out_ready_i) begin
        state_d  = IDLE;
        onehot_d = '0;
        valid_d  = 1'b0;
      end
      default: state_d = IDLE;
    endcase
  end
  // clear takes effect before a same-edge reject is counted
  assign err_base   = err_clr_i ? '0 : err_cnt_q;
  assign err_cnt_d  = reject && !(&err_base) ? err_base + 1'b1 : err_base;
  assign err_flag_d = reject | (err_flag_q & ~err_clr_i);
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= IDLE;
      onehot_q   <= '0;
      valid_q    <= 1'b0;
      cnt_q      <= '0;
      err_cnt_q  <= '0;
      err_flag_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      onehot_q   <= onehot_d;
      valid_q    <= valid_d;
      cnt_q      <= cnt_d;
      err_cnt_q  <= err_cnt_d;
      err_flag_q <= err_flag_d;
    end
  end
endmodule

// File: tb/tb_onehot_decoder_hs.sv
// tb_onehot_decoder_hs: directed self-checking bench for onehot_decoder_hs
module tb_onehot_decoder_hs;
  logic       clk = 1'b0;
  logic       rst;
  logic       in_valid, in_ready, in_invalid, out_valid, out_ready, busy, err_clr, err_flag;
  logic [2:0] in_idx;
  logic [7:0] out_onehot, err_count;
  int total = 0;
  int bad   = 0;

  onehot_decoder_hs dut (
    .clk(clk), .rst(rst),
    .in_valid_i(in_valid), .in_ready_o(in_ready), .in_idx_i(in_idx), .in_invalid_i(in_invalid),
    .out_onehot_o(out_onehot), .out_valid_o(out_valid), .out_ready_i(out_ready),
    .busy_o(busy), .err_clr_i(err_clr), .err_count_o(err_count), .err_flag_o(err_flag)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst = 1'b1; in_valid = 0; in_idx = 0; in_invalid = 0; out_ready = 1; err_clr = 0;
    #3;
    chk("rst_valid", out_valid, 0);
    chk("rst_onehot", out_onehot, 0);
    chk("rst_ready", in_ready, 1);
    chk("rst_busy", busy, 0);
    chk("rst_errcnt", err_count, 0);
    chk("rst_errflag", err_flag, 0);
    step(); rst = 1'b0; step();

    // 1: single transaction, out_valid high exactly 4 cycles
    in_idx = 3'd5; in_valid = 1;
    step(); in_valid = 0;
    chk("t1_onehot", out_onehot, 8'h20);
    chk("t1_valid", out_valid, 1);
    chk("t1_ready", in_ready, 0);
    for (int i = 1; i < 4; i++) begin
      step();
      chk("t1_hold_valid", out_valid, 1);
      chk("t1_hold_onehot", out_onehot, 8'h20);
      chk("t1_hold_ready", in_ready, 0);
    end
    step();
    chk("t1_rel_valid", out_valid, 0);
    chk("t1_rel_onehot", out_onehot, 0);
    chk("t1_rel_ready", in_ready, 1);

    // 2: back-to-back sweep, in_valid held; idx changes mid-hold must be ignored
    in_valid = 1; in_idx = 0;
    for (int k = 0; k < 8; k++) begin
      step();
      chk("t2_onehot", out_onehot, 32'h1 << k);
      chk("t2_busy", busy, 1);
      in_idx = 3'(k + 1);
      step(); step();
      chk("t2_stable", out_onehot, 32'h1 << k);
      step(); step();
      chk("t2_ready", in_ready, 1);
      chk("t2_relvalid", out_valid, 0);
    end
    in_valid = 0;

    // 3: invalid input rejected and counted
    in_invalid = 1; in_idx = 3'd3; in_valid = 1;
    step(); in_valid = 0; in_invalid = 0;
    chk("t3_valid", out_valid, 0);
    chk("t3_onehot", out_onehot, 0);
    chk("t3_errcnt", err_count, 1);
    chk("t3_errflag", err_flag, 1);
    chk("t3_ready", in_ready, 1);

    // 4: downstream stall holds output through WAIT
    out_ready = 0; in_idx = 3'd2; in_valid = 1;
    step(); in_valid = 0;
    chk("t4_onehot", out_onehot, 8'h04);
    for (int i = 1; i < 10; i++) begin
      step();
      chk("t4_hold_valid", out_valid, 1);
      chk("t4_hold_onehot", out_onehot, 8'h04);
      chk("t4_hold_busy", busy, 1);
    end
    out_ready = 1;
    step();
    chk("t4_rel_valid", out_valid, 0);
    chk("t4_rel_onehot", out_onehot, 0);
    chk("t4_rel_ready", in_ready, 1);
    chk("t4_errcnt", err_count, 1);

    // 5: saturation, then clear coinciding with a reject
    err_clr = 1;
    step(); err_clr = 0;
    chk("t5_clr_cnt", err_count, 0);
    chk("t5_clr_flag", err_flag, 0);
    in_valid = 1; in_invalid = 1;
    for (int i = 0; i < 260; i++) step();
    chk("t5_sat_cnt", err_count, 255);
    chk("t5_sat_valid", out_valid, 0);
    err_clr = 1;
    step(); err_clr = 0; in_valid = 0; in_invalid = 0;
    chk("t5_clrrej_cnt", err_count, 1);
    chk("t5_clrrej_flag", err_flag, 1);

    // 6: asynchronous reset mid-HOLD
    in_idx = 3'd6; in_valid = 1;
    step(); in_valid = 0;
    chk("t6_onehot", out_onehot, 8'h40);
    step();
    #2 rst = 1;
    #1;
    chk("t6_valid", out_valid, 0);
    chk("t6_onehot_rst", out_onehot, 0);
    chk("t6_ready", in_ready, 1);
    chk("t6_errcnt", err_count, 0);
    step(); rst = 0;
    in_idx = 3'd7; in_valid = 1;
    step(); in_valid = 0;
    chk("t6_recover", out_onehot, 8'h80);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
